// File: rtl/pipe_stage_reg_if.sv
// Bundles the upstream inputs and registered outputs of one inter-stage pipeline register.
// The slave side belongs to the register. The master side belongs to whatever drives it.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 160,
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 16
);
    logic              stall;
    logic              flush;
    logic              valid_i;
    logic [DATA_W-1:0] data_i;
    logic              regwrite_i;
    logic [4:0]        a3_i;
    logic [TNEW_W-1:0] tnew_i;

    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic              regwrite_o;
    logic [4:0]        a3_o;
    logic [TNEW_W-1:0] tnew_o;
    logic              fwd_ready_o;
    logic [CNT_W-1:0]  stall_cnt_o;
    logic [CNT_W-1:0]  flush_cnt_o;

    modport master (
        output stall, flush, valid_i, data_i, regwrite_i, a3_i, tnew_i,
        input  valid_o, data_o, regwrite_o, a3_o, tnew_o, fwd_ready_o,
               stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  stall, flush, valid_i, data_i, regwrite_i, a3_i, tnew_i,
        output valid_o, data_o, regwrite_o, a3_o, tnew_o, fwd_ready_o,
               stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Reusable D/E, E/M, M/W pipeline register. It supports stall and flush, counts down T_new,
// reports forwarding readiness and keeps saturating stall and flush counters.
module pipe_stage_reg #(
    parameter int DATA_W = 160,
    parameter int TNEW_W = 2,
    parameter int CNT_W  = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_stage_reg_if.slave  bus
);

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              regwrite_q,  regwrite_d;
    logic [4:0]        a3_q,        a3_d;
    logic [TNEW_W-1:0] tnew_q,      tnew_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
        return (x == '0) ? '0 : x - TNEW_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
        return (x == {CNT_W{1'b1}}) ? x : x + CNT_W'(1);
    endfunction

    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        regwrite_d  = regwrite_q;
        a3_d        = a3_q;
        tnew_d      = tnew_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        if (bus.flush) begin
            valid_d     = 1'b0;
            data_d      = '0;
            regwrite_d  = 1'b0;
            a3_d        = '0;
            tnew_d      = '0;
            flush_cnt_d = sat_inc(flush_cnt_q);
        end else if (bus.stall) begin
            tnew_d = sat_dec(tnew_q);
            // A held bubble is not a lost instruction slot, so it is not counted.
            if (valid_q) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
        end else begin
            valid_d    = bus.valid_i;
            data_d     = bus.data_i;
            a3_d       = bus.a3_i;
            // Squash writes to $0 here so the hazard unit never sees them.
            regwrite_d = bus.valid_i & bus.regwrite_i & (bus.a3_i != 5'd0);
            tnew_d     = bus.valid_i ? sat_dec(bus.tnew_i) : '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= 1'b0;
            data_q      <= '0;
            regwrite_q  <= 1'b0;
            a3_q        <= '0;
            tnew_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            regwrite_q  <= regwrite_d;
            a3_q        <= a3_d;
            tnew_q      <= tnew_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.data_o      = data_q;
    assign bus.regwrite_o  = regwrite_q;
    assign bus.a3_o        = a3_q;
    assign bus.tnew_o      = tnew_q;
    assign bus.fwd_ready_o = valid_q & regwrite_q & (tnew_q == '0);
    assign bus.stall_cnt_o = stall_cnt_q;
    assign bus.flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg. One instance uses default widths.
// A second instance uses CNT_W=2 to exercise counter saturation.
module tb_pipe_stage_reg;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.DATA_W(160), .TNEW_W(2), .CNT_W(16)) bus ();
    pipe_stage_reg_if #(.DATA_W(160), .TNEW_W(2), .CNT_W(2))  bus2 ();

    pipe_stage_reg #(.DATA_W(160), .TNEW_W(2), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    pipe_stage_reg #(.DATA_W(160), .TNEW_W(2), .CNT_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic fl, input logic v, input logic [159:0] d,
                         input logic rw, input logic [4:0] a3, input logic [1:0] tn);
        bus.stall      = st;
        bus.flush      = fl;
        bus.valid_i    = v;
        bus.data_i     = d;
        bus.regwrite_i = rw;
        bus.a3_i       = a3;
        bus.tnew_i     = tn;
    endtask

    task automatic drive2(input logic st, input logic fl, input logic v, input logic rw,
                          input logic [4:0] a3, input logic [1:0] tn);
        bus2.stall      = st;
        bus2.flush      = fl;
        bus2.valid_i    = v;
        bus2.data_i     = 160'h77;
        bus2.regwrite_i = rw;
        bus2.a3_i       = a3;
        bus2.tnew_i     = tn;
    endtask

    initial begin
        drive2(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0);
        // Drive a valid instruction during reset. Nothing may load while reset is low.
        drive(1'b0, 1'b0, 1'b1, 160'hABCD, 1'b1, 5'd8, 2'd2);
        edge1();
        edge1();
        chk("rst_valid",    bus.valid_o,     0);
        chk("rst_data",     bus.data_o,      0);
        chk("rst_regwrite", bus.regwrite_o,  0);
        chk("rst_a3",       bus.a3_o,        0);
        chk("rst_tnew",     bus.tnew_o,      0);
        chk("rst_fwd",      bus.fwd_ready_o, 0);
        chk("rst_scnt",     bus.stall_cnt_o, 0);
        chk("rst_fcnt",     bus.flush_cnt_o, 0);

        reset = 1'b1;
        edge1();
        chk("load_valid",    bus.valid_o,     1);
        chk("load_data",     bus.data_o,      160'hABCD);
        chk("load_a3",       bus.a3_o,        8);
        chk("load_tnew",     bus.tnew_o,      1);
        chk("load_regwrite", bus.regwrite_o,  1);
        chk("load_fwd",      bus.fwd_ready_o, 0);

        // Stall for three edges. T_new counts 1 -> 0 -> 0.
        bus.stall = 1'b1;
        edge1();
        chk("st1_tnew", bus.tnew_o,      0);
        chk("st1_fwd",  bus.fwd_ready_o, 1);
        chk("st1_scnt", bus.stall_cnt_o, 1);
        edge1();
        chk("st2_tnew", bus.tnew_o,      0);
        chk("st2_scnt", bus.stall_cnt_o, 2);
        edge1();
        chk("st3_data", bus.data_o,      160'hABCD);
        chk("st3_tnew", bus.tnew_o,      0);
        chk("st3_scnt", bus.stall_cnt_o, 3);
        chk("st3_fwd",  bus.fwd_ready_o, 1);

        // A write to $0 is squashed.
        drive(1'b0, 1'b0, 1'b1, 160'h1234, 1'b1, 5'd0, 2'd0);
        edge1();
        chk("z0_regwrite", bus.regwrite_o,  0);
        chk("z0_fwd",      bus.fwd_ready_o, 0);
        chk("z0_valid",    bus.valid_o,     1);
        chk("z0_data",     bus.data_o,      160'h1234);

        // Maximum T_new loads as max-1.
        drive(1'b0, 1'b0, 1'b1, 160'h55, 1'b1, 5'd5, 2'd3);
        edge1();
        chk("tmax_tnew",     bus.tnew_o,      2);
        chk("tmax_regwrite", bus.regwrite_o,  1);
        chk("tmax_fwd",      bus.fwd_ready_o, 0);

        // Flush takes priority over stall.
        drive(1'b1, 1'b1, 1'b1, 160'h99, 1'b1, 5'd6, 2'd1);
        edge1();
        chk("fl_valid",    bus.valid_o,     0);
        chk("fl_data",     bus.data_o,      0);
        chk("fl_regwrite", bus.regwrite_o,  0);
        chk("fl_a3",       bus.a3_o,        0);
        chk("fl_tnew",     bus.tnew_o,      0);
        chk("fl_fcnt",     bus.flush_cnt_o, 1);
        chk("fl_scnt",     bus.stall_cnt_o, 3);

        // A bubble held under stall is not counted.
        bus.flush = 1'b0;
        edge1();
        chk("bub_scnt",  bus.stall_cnt_o, 3);
        chk("bub_valid", bus.valid_o,     0);

        // Loading an invalid instruction clears regwrite and T_new.
        drive(1'b0, 1'b0, 1'b0, 160'h42, 1'b1, 5'd7, 2'd2);
        edge1();
        chk("inv_valid",    bus.valid_o,    0);
        chk("inv_regwrite", bus.regwrite_o, 0);
        chk("inv_tnew",     bus.tnew_o,     0);
        chk("inv_a3",       bus.a3_o,       7);

        // Build up valid_o=1 and stall_cnt=5, then assert reset between clock edges.
        drive(1'b0, 1'b0, 1'b1, 160'hBEEF, 1'b1, 5'd9, 2'd1);
        edge1();
        chk("ar_pre_fwd", bus.fwd_ready_o, 1);
        bus.stall = 1'b1;
        edge1();
        edge1();
        chk("ar_pre_scnt", bus.stall_cnt_o, 5);
        bus.stall = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("ar_valid", bus.valid_o,     0);
        chk("ar_data",  bus.data_o,      0);
        chk("ar_a3",    bus.a3_o,        0);
        chk("ar_scnt",  bus.stall_cnt_o, 0);
        chk("ar_fcnt",  bus.flush_cnt_o, 0);
        edge1();
        chk("ar_hold_valid", bus.valid_o, 0);
        chk("ar_hold_data",  bus.data_o,  0);
        #2;
        reset = 1'b1;
        edge1();
        chk("ar_rel_valid", bus.valid_o, 1);
        chk("ar_rel_data",  bus.data_o,  160'hBEEF);

        // Saturation with CNT_W=2.
        drive2(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 2'd0);
        edge1();
        chk("sat_load_valid", bus2.valid_o, 1);
        bus2.stall = 1'b1;
        edge1(); chk("sat_s1", bus2.stall_cnt_o, 1);
        edge1(); chk("sat_s2", bus2.stall_cnt_o, 2);
        edge1(); chk("sat_s3", bus2.stall_cnt_o, 3);
        edge1(); chk("sat_s4", bus2.stall_cnt_o, 3);
        edge1(); chk("sat_s5", bus2.stall_cnt_o, 3);
        edge1(); chk("sat_s6", bus2.stall_cnt_o, 3);
        bus2.stall = 1'b0;
        bus2.flush = 1'b1;
        edge1(); chk("sat_f1", bus2.flush_cnt_o, 1);
        edge1(); chk("sat_f2", bus2.flush_cnt_o, 2);
        edge1(); chk("sat_f3", bus2.flush_cnt_o, 3);
        edge1(); chk("sat_f4", bus2.flush_cnt_o, 3);
        edge1(); chk("sat_f5", bus2.flush_cnt_o, 3);
        chk("sat_scnt_kept", bus2.stall_cnt_o, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the 5-stage MIPS core.
- Generalises the fixed-field D/E register into one reusable block for D/E, E/M and M/W.
- Carries a valid bit and an opaque payload.
- Supports stall (hold) and flush (bubble insert), tracks a per-instruction T_new countdown and exports hazard/forwarding info.
- Keeps saturating stall and flush performance counters.

Parameters:
- DATA_W, 160, width of opaque payload (PC, RD1, RD2, imm, opcode, ...)
- TNEW_W, 2, width of T_new field (cycles until the write-back value is produced)
- CNT_W, 16, width of performance counters

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold current contents
- flush  in  1  replace contents with a bubble
- valid_i  in  1  upstream instruction valid
- data_i  in  DATA_W  upstream payload
- regwrite_i  in  1  upstream instruction writes GPR
- a3_i  in  5  upstream destination register
- tnew_i  in  TNEW_W  upstream T_new
- valid_o  out  1  stage holds a real instruction
- data_o  out  DATA_W  registered payload
- regwrite_o  out  1  registered write enable (hazard unit)
- a3_o  out  5  registered destination (hazard unit)
- tnew_o  out  TNEW_W  remaining T_new
- fwd_ready_o  out  1  value forwardable from this stage
- stall_cnt_o  out  CNT_W  held cycles
- flush_cnt_o  out  CNT_W  flush events

Behaviour:
- Reset (reset=0, asynchronous, any time): all outputs and counters go to 0 immediately; stays 0 while reset=0. First load happens on the first rising edge after reset=1.
- Latency: one cycle, input to output, when loading.
- Per-edge priority: flush > stall > load.
- flush=1 (with or without stall):
  - valid_o, regwrite_o, a3_o, tnew_o, data_o <= 0.
  - flush_cnt_o += 1, saturating at 2^CNT_W-1.
  - stall_cnt_o unchanged.
- stall=1, flush=0 (hold):
  - valid_o, data_o, regwrite_o, a3_o held.
  - tnew_o <= sat_dec(tnew_o), where sat_dec(x) = (x==0) ? 0 : x-1.
  - stall_cnt_o += 1 (saturating) only if valid_o=1. Bubbles held under stall are not counted.
- Neither asserted (load):
  - valid_o <= valid_i.
  - data_o <= data_i.
  - a3_o <= a3_i.
  - regwrite_o <= valid_i & regwrite_i & (a3_i != 0). Writes to $0 are squashed here.
  - tnew_o <= sat_dec(tnew_i).
  - If valid_i=0: regwrite_o=0 and tnew_o=0; data_o is still loaded but is don't-care.
- fwd_ready_o = valid_o & regwrite_o & (tnew_o == 0). Purely combinational from registered state, no input path.
- Counters never wrap. At max they hold until reset.
- Wide TNEW_W: sat_dec is exact for all widths. tnew_i at max value loads as max-1.
- Invariant after every edge: regwrite_o=1 implies valid_o=1 and a3_o != 0.

Test Plan:
- Reset then load: reset=0 for 2 cycles; release; load valid_i=1, data_i=0xABCD, regwrite_i=1, a3_i=8, tnew_i=2 -> during reset all outputs 0; after 1 edge valid_o=1, data_o=0xABCD, a3_o=8, tnew_o=1, fwd_ready_o=0.
- Stall countdown: from previous state, stall=1 for 3 edges -> tnew_o 1->0->0, fwd_ready_o=1 after first stall edge, data_o held 0xABCD, stall_cnt_o=3.
- $0 squash: load regwrite_i=1, a3_i=0, tnew_i=0 -> regwrite_o=0, fwd_ready_o=0, valid_o=1.
- Flush priority: flush=1 and stall=1 on the same edge while holding a valid instruction -> all payload/control outputs 0, flush_cnt_o+1, stall_cnt_o unchanged.
- Async reset mid-operation: assert reset=0 between clock edges while valid_o=1, stall_cnt_o=5 -> outputs and counters 0 before the next edge; no load occurs until reset=1.
- Saturation with CNT_W=2: hold stall=1 with a valid instruction for 6 cycles -> stall_cnt_o reads 1,2,3,3,3,3. Issue 5 flushes -> flush_cnt_o ends at 3.
